// File: rtl/change_dispenser_if.sv
// Coin hopper handshake: dispenser offers one coin at a time, hopper accepts it.
interface change_dispenser_if;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       coin_ready;

    modport master (
        output coin_valid,
        output coin_code,
        input  coin_ready
    );

    modport slave (
        input  coin_valid,
        input  coin_code,
        output coin_ready
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout (4, 2, 1) from tracked per-denomination stock to a coin hopper.
module change_dispenser #(
    parameter int unsigned AMT_W    = 5,
    parameter int unsigned INV_W    = 4,
    parameter int unsigned INV_INIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AMT_W-1:0]     amount,
    input  logic                 refill,
    input  logic [INV_W-1:0]     refill_c1,
    input  logic [INV_W-1:0]     refill_c2,
    input  logic [INV_W-1:0]     refill_c4,
    output logic                 busy,
    output logic                 done,
    output logic [AMT_W-1:0]     shortfall,
    output logic [INV_W-1:0]     inv_c1,
    output logic [INV_W-1:0]     inv_c2,
    output logic [INV_W-1:0]     inv_c4,
    change_dispenser_if.master   hopper
);

    typedef enum logic [1:0] {StIdle, StSelect, StPay, StDone} state_e;

    localparam logic [1:0]       Code1   = 2'b01;
    localparam logic [1:0]       Code2   = 2'b10;
    localparam logic [1:0]       Code4   = 2'b11;
    localparam logic [INV_W-1:0] InvInit = INV_W'(INV_INIT);
    localparam logic [INV_W-1:0] InvOne  = INV_W'(1);

    state_e           state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [AMT_W-1:0] shortfall_q, shortfall_d;
    logic [1:0]       code_q, code_d;
    logic [INV_W-1:0] c1_q, c1_d;
    logic [INV_W-1:0] c2_q, c2_d;
    logic [INV_W-1:0] c4_q, c4_d;
    logic [AMT_W-1:0] coin_amt;

    // Value of the coin currently being offered.
    always_comb begin
        coin_amt = '0;
        unique case (code_q)
            Code4:   coin_amt = AMT_W'(4);
            Code2:   coin_amt = AMT_W'(2);
            Code1:   coin_amt = AMT_W'(1);
            default: coin_amt = '0;
        endcase
    end

    // State and datapath registers; async reset abandons any in-flight coin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            shortfall_q <= '0;
            code_q      <= 2'b00;
            c1_q        <= InvInit;
            c2_q        <= InvInit;
            c4_q        <= InvInit;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            shortfall_q <= shortfall_d;
            code_q      <= code_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            c4_q        <= c4_d;
        end
    end

    // Next-state logic: greedy selection skips denominations that are out of stock.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        shortfall_d = shortfall_q;
        code_d      = code_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        c4_d        = c4_q;
        unique case (state_q)
            StIdle: begin
                if (refill) begin
                    c1_d = refill_c1;
                    c2_d = refill_c2;
                    c4_d = refill_c4;
                end
                if (start) begin
                    remaining_d = amount;
                    shortfall_d = '0;
                    state_d     = StSelect;
                end
            end
            StSelect: begin
                if (remaining_q >= AMT_W'(4) && c4_q != '0) begin
                    code_d  = Code4;
                    state_d = StPay;
                end else if (remaining_q >= AMT_W'(2) && c2_q != '0) begin
                    code_d  = Code2;
                    state_d = StPay;
                end else if (remaining_q >= AMT_W'(1) && c1_q != '0) begin
                    code_d  = Code1;
                    state_d = StPay;
                end else begin
                    // Nothing left to pay or nothing payable: latch the unpaid remainder.
                    shortfall_d = remaining_q;
                    state_d     = StDone;
                end
            end
            StPay: begin
                if (hopper.coin_ready) begin
                    remaining_d = remaining_q - coin_amt;
                    unique case (code_q)
                        Code4:   c4_d = c4_q - InvOne;
                        Code2:   c2_d = c2_q - InvOne;
                        Code1:   c1_d = c1_q - InvOne;
                        default: ;
                    endcase
                    state_d = StSelect;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        busy              = (state_q != StIdle);
        done              = (state_q == StDone);
        hopper.coin_valid = (state_q == StPay);
        hopper.coin_code  = (state_q == StPay) ? code_q : 2'b00;
    end

    assign shortfall = shortfall_q;
    assign inv_c1    = c1_q;
    assign inv_c2    = c2_q;
    assign inv_c4    = c4_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench: stimulus queues expected coins/done, a negedge monitor checks them.
module tb_change_dispenser;
    localparam int AMT_W = 5;
    localparam int INV_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             refill;
    logic [INV_W-1:0] refill_c1, refill_c2, refill_c4;
    logic             busy, done;
    logic [AMT_W-1:0] shortfall;
    logic [INV_W-1:0] inv_c1, inv_c2, inv_c4;

    change_dispenser_if hop ();

    change_dispenser #(
        .AMT_W   (AMT_W),
        .INV_W   (INV_W),
        .INV_INIT(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .amount   (amount),
        .refill   (refill),
        .refill_c1(refill_c1),
        .refill_c2(refill_c2),
        .refill_c4(refill_c4),
        .busy     (busy),
        .done     (done),
        .shortfall(shortfall),
        .inv_c1   (inv_c1),
        .inv_c2   (inv_c2),
        .inv_c4   (inv_c4),
        .hopper   (hop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_done;
        logic [1:0] code;
        int         at;
        int         sf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every hopper handshake and done pulse against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (hop.coin_valid && !hop.coin_ready && sb.size() > 0 && !sb[0].is_done)
                check("stall_code", int'(hop.coin_code), int'(sb[0].code));
            if (hop.coin_valid && hop.coin_ready) begin
                if (sb.size() == 0 || sb[0].is_done) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_coin: got code %0d expected no coin (cycle %0d)",
                             hop.coin_code, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("coin_code", int'(hop.coin_code), int'(mon_e.code));
                    check("coin_cycle", cyc, mon_e.at);
                end
            end
            if (done) begin
                if (sb.size() == 0 || !sb[0].is_done) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_cycle", cyc, mon_e.at);
                    check("done_shortfall", int'(shortfall), mon_e.sf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_inv(input string name, input int e1, input int e2, input int e4);
        check({name, "_c1"}, int'(inv_c1), e1);
        check({name, "_c2"}, int'(inv_c2), e2);
        check({name, "_c4"}, int'(inv_c4), e4);
    endtask

    // One payout: start (optionally with refill), queue expectations, optional stall/poke.
    task automatic pay(input int amt, input int n, input logic [1:0] k0, input logic [1:0] k1,
                       input logic [1:0] k2, input int sf, input int stall,
                       input bit do_refill, input int r1, input int r2, input int r4,
                       input bit poke);
        logic [1:0] codes[3];
        exp_t       e;
        int         base;
        codes[0] = k0;
        codes[1] = k1;
        codes[2] = k2;
        start     = 1'b1;
        amount    = AMT_W'(amt);
        refill    = do_refill;
        refill_c1 = INV_W'(r1);
        refill_c2 = INV_W'(r2);
        refill_c4 = INV_W'(r4);
        tick();
        start  = 1'b0;
        refill = 1'b0;
        base   = cyc;
        for (int i = 0; i < n; i++) begin
            e.is_done = 1'b0;
            e.code    = codes[i];
            e.at      = base + 1 + stall + 2 * i;
            e.sf      = 0;
            sb.push_back(e);
        end
        e.is_done = 1'b1;
        e.code    = 2'b00;
        e.at      = base + 1 + stall + 2 * n;
        e.sf      = sf;
        sb.push_back(e);
        if (poke) begin
            start     = 1'b1;
            amount    = 5'd31;
            refill    = 1'b1;
            refill_c1 = '0;
            refill_c2 = '0;
            refill_c4 = '0;
            repeat (3) tick();
            start  = 1'b0;
            refill = 1'b0;
        end
        if (stall > 0) begin
            repeat (stall + 1) tick();
            hop.coin_ready = 1'b1;
        end
        for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_refill(input int r1, input int r2, input int r4);
        refill    = 1'b1;
        refill_c1 = INV_W'(r1);
        refill_c2 = INV_W'(r2);
        refill_c4 = INV_W'(r4);
        tick();
        refill = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        amount         = '0;
        refill         = 1'b0;
        refill_c1      = '0;
        refill_c2      = '0;
        refill_c4      = '0;
        hop.coin_ready = 1'b1;
        repeat (2) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(hop.coin_valid), 0);
        check("rst_code", int'(hop.coin_code), 0);
        check("rst_done", int'(done), 0);
        check("rst_shortfall", int'(shortfall), 0);
        check_inv("rst_inv", 8, 8, 8);
        rst = 1'b0;
        tick();

        // 7 = 4+2+1 with ready high.
        pay(7, 3, 2'b11, 2'b10, 2'b01, 0, 0, 1'b0, 0, 0, 0, 1'b0);
        check_inv("t1_inv", 7, 7, 7);

        // Same payout with a 3-cycle stall on the first coin.
        hop.coin_ready = 1'b0;
        pay(7, 3, 2'b11, 2'b10, 2'b01, 0, 3, 1'b0, 0, 0, 0, 1'b0);
        check_inv("t2_inv", 6, 6, 6);

        // No 4-coins: 6 = 2+2+2.
        do_refill(8, 8, 0);
        check_inv("t3_refill", 8, 8, 0);
        pay(6, 3, 2'b10, 2'b10, 2'b10, 0, 0, 1'b0, 0, 0, 0, 1'b0);
        check_inv("t3_inv", 8, 5, 0);

        // Insufficient stock: 7 pays 4+1, shortfall 2.
        do_refill(1, 0, 1);
        pay(7, 2, 2'b11, 2'b01, 2'b00, 2, 0, 1'b0, 0, 0, 0, 1'b0);
        check_inv("t4_inv", 0, 0, 0);
        repeat (3) tick();
        check("t4_sf_hold", int'(shortfall), 2);

        // Zero amount clears shortfall, pays nothing.
        pay(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 0, 0, 0, 1'b0);

        // Refill with start in the same cycle, then start/refill pokes while busy.
        pay(5, 2, 2'b11, 2'b01, 2'b00, 0, 0, 1'b1, 8, 8, 8, 1'b1);
        check_inv("t5_inv", 7, 8, 7);
        check("t5_busy", int'(busy), 0);

        // Reset while stalled in PAY.
        hop.coin_ready = 1'b0;
        start  = 1'b1;
        amount = 5'd3;
        tick();
        start = 1'b0;
        tick();
        check("t6_pay_valid", int'(hop.coin_valid), 1);
        check("t6_pay_code", int'(hop.coin_code), 2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", int'(hop.coin_valid), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_code", int'(hop.coin_code), 0);
        check_inv("t6_rst_inv", 8, 8, 8);
        tick();
        rst            = 1'b0;
        hop.coin_ready = 1'b1;
        tick();
        pay(7, 3, 2'b11, 2'b10, 2'b01, 0, 0, 1'b0, 0, 0, 0, 1'b0);
        check_inv("t6_inv", 7, 7, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
